// File: rtl/uart_baud_gen.sv
// UART baud-rate timebase: a programmable prescaler makes oversample ticks, and a
// sub-bit counter turns those ticks into single-cycle baud and double-rate strobes.
module uart_baud_gen #(
    parameter int DIV_WIDTH  = 16,
    parameter int OVERSAMPLE = 16,
    parameter int RESET_DIV  = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] divisor_i,
    input  logic                 divisor_valid_i,
    input  logic                 resync_i,
    output logic                 oversample_edge_o,
    output logic                 baud_rate_edge_o,
    output logic                 double_rate_edge_o,
    output logic [DIV_WIDTH-1:0] divisor_o
);

    localparam int SUB_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_WIDTH-1:0] RST_DIV  = DIV_WIDTH'(RESET_DIV);
    localparam logic [DIV_WIDTH-1:0] RST_CNT  = (RESET_DIV == 0) ? '0 : DIV_WIDTH'(RESET_DIV - 1);
    localparam logic [SUB_W-1:0]     SUB_LAST = SUB_W'(OVERSAMPLE - 1);
    localparam logic [SUB_W-1:0]     SUB_HALF = SUB_W'(OVERSAMPLE / 2 - 1);

    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [SUB_W-1:0]     sub_q, sub_d;
    logic                 active;
    logic                 tick;

    // Prescaler reload value; a zero divisor parks the counter at zero.
    function automatic logic [DIV_WIDTH-1:0] reload_sat(input logic [DIV_WIDTH-1:0] d);
        return (d == '0) ? '0 : d - DIV_WIDTH'(1);
    endfunction

    function automatic logic [SUB_W-1:0] sub_wrap(input logic [SUB_W-1:0] s);
        return (s == SUB_LAST) ? '0 : s + SUB_W'(1);
    endfunction

    assign active = en_i & (div_q != '0);
    assign tick   = active & (cnt_q == '0);

    // Strobes decode only registered state plus the enable gate, so a strobe
    // arriving this cycle never alters this cycle's edges.
    assign oversample_edge_o  = tick;
    assign baud_rate_edge_o   = tick & (sub_q == SUB_LAST);
    assign double_rate_edge_o = tick & ((sub_q == SUB_LAST) | (sub_q == SUB_HALF));
    assign divisor_o          = div_q;

    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        sub_d = sub_q;
        if (divisor_valid_i) begin
            div_d = divisor_i;
            cnt_d = reload_sat(divisor_i);
            sub_d = '0;
        end else if (resync_i || !active) begin
            cnt_d = reload_sat(div_q);
            sub_d = '0;
        end else if (cnt_q == '0) begin
            cnt_d = reload_sat(div_q);
            sub_d = sub_wrap(sub_q);
        end else begin
            cnt_d = cnt_q - DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q <= RST_DIV;
            cnt_q <= RST_CNT;
            sub_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
            sub_q <= sub_d;
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: a directed vector table for the D=1 / stop
// cases plus hand-written sequences for load, resync, enable-drop and async reset.
module tb_uart_baud_gen;

    localparam int DW = 16;
    localparam int OS = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          en_i;
    logic [DW-1:0] divisor_i;
    logic          divisor_valid_i;
    logic          resync_i;
    logic          oversample_edge_o;
    logic          baud_rate_edge_o;
    logic          double_rate_edge_o;
    logic [DW-1:0] divisor_o;

    uart_baud_gen #(.DIV_WIDTH(DW), .OVERSAMPLE(OS), .RESET_DIV(0)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .en_i               (en_i),
        .divisor_i          (divisor_i),
        .divisor_valid_i    (divisor_valid_i),
        .resync_i           (resync_i),
        .oversample_edge_o  (oversample_edge_o),
        .baud_rate_edge_o   (baud_rate_edge_o),
        .double_rate_edge_o (double_rate_edge_o),
        .divisor_o          (divisor_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    logic          s_os, s_baud, s_dbl;
    logic [DW-1:0] s_div;

    typedef struct {
        logic          en;
        logic          dv;
        logic [DW-1:0] div;
        logic          rs;
        logic          os;
        logic          baud;
        logic          dbl;
        logic [DW-1:0] divo;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input logic en, input logic dv, input int div, input logic rs,
                                input logic os, input logic baud, input logic dbl, input int divo);
        vec_t v;
        v.en = en; v.dv = dv; v.div = DW'(div); v.rs = rs;
        v.os = os; v.baud = baud; v.dbl = dbl; v.divo = DW'(divo);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the rising edge, sample at the falling edge.
    task automatic cyc(input logic en, input logic dv, input int div, input logic rs);
        en_i            = en;
        divisor_valid_i = dv;
        divisor_i       = DW'(div);
        resync_i        = rs;
        @(negedge clk_i);
        s_os   = oversample_edge_o;
        s_baud = baud_rate_edge_o;
        s_dbl  = double_rate_edge_o;
        s_div  = divisor_o;
        @(posedge clk_i);
        #1;
    endtask

    // Runs n enabled cycles after a restart in cycle T (k = cycles since T) and
    // compares every strobe against its ideal period for divisor d.
    task automatic run_from(input string name, input int d, input int n);
        int bad_os = 0, bad_dbl = 0, bad_baud = 0, bad_div = 0, first_bad = 0;
        for (int k = 1; k <= n; k++) begin
            cyc(1'b1, 1'b0, 0, 1'b0);
            if (s_os   != ((k % d) == 0))             bad_os++;
            if (s_dbl  != ((k % (d * OS / 2)) == 0))  bad_dbl++;
            if (s_baud != ((k % (d * OS)) == 0))      bad_baud++;
            if (s_div  != DW'(d))                      bad_div++;
            if (first_bad == 0 && (bad_os + bad_dbl + bad_baud + bad_div) != 0) first_bad = k;
        end
        chk({name, "_os_bad"},   bad_os,   0);
        chk({name, "_dbl_bad"},  bad_dbl,  0);
        chk({name, "_baud_bad"}, bad_baud, 0);
        chk({name, "_div_bad"},  bad_div,  0);
        if (first_bad != 0) $display("  %s first deviation at cycle +%0d", name, first_bad);
    endtask

    initial begin
        int pulses;

        tbl[0]  = mk(1, 0, 0, 0,  0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 1, 0,  0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0,  1, 0, 0, 1);
        tbl[3]  = mk(1, 0, 0, 0,  1, 0, 0, 1);
        tbl[4]  = mk(1, 0, 0, 0,  1, 0, 0, 1);
        tbl[5]  = mk(1, 0, 0, 0,  1, 0, 0, 1);
        tbl[6]  = mk(1, 0, 0, 0,  1, 0, 0, 1);
        tbl[7]  = mk(1, 0, 0, 0,  1, 0, 0, 1);
        tbl[8]  = mk(1, 0, 0, 0,  1, 0, 0, 1);
        tbl[9]  = mk(1, 0, 0, 0,  1, 0, 1, 1);
        tbl[10] = mk(0, 0, 0, 0,  0, 0, 0, 1);
        tbl[11] = mk(1, 0, 0, 1,  1, 0, 0, 1);
        tbl[12] = mk(1, 0, 0, 0,  1, 0, 0, 1);
        tbl[13] = mk(1, 1, 0, 0,  1, 0, 0, 1);
        tbl[14] = mk(1, 0, 0, 0,  0, 0, 0, 0);

        rst_i = 1'b1; en_i = 1'b0; divisor_i = '0; divisor_valid_i = 1'b0; resync_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_divisor", int'(divisor_o), 0);
        chk("rst_os", int'(oversample_edge_o), 0);
        rst_i = 1'b0;

        // RESET_DIV=0 keeps the generator stopped even when enabled.
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 1'b0, 0, 1'b0);
            pulses += int'(s_os) + int'(s_baud) + int'(s_dbl);
        end
        chk("stopped_pulses", pulses, 0);
        chk("stopped_divisor", int'(s_div), 0);

        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].en, tbl[i].dv, int'(tbl[i].div), tbl[i].rs);
            chk($sformatf("vec%0d_os", i),   int'(s_os),   int'(tbl[i].os));
            chk($sformatf("vec%0d_baud", i), int'(s_baud), int'(tbl[i].baud));
            chk($sformatf("vec%0d_dbl", i),  int'(s_dbl),  int'(tbl[i].dbl));
            chk($sformatf("vec%0d_divo", i), int'(s_div),  int'(tbl[i].divo));
        end

        cyc(1'b1, 1'b1, 3, 1'b0);
        run_from("d3", 3, 100);

        cyc(1'b1, 1'b1, 1, 1'b0);
        run_from("d1", 1, 40);

        // D=5: the 10th tick after the load has sub index 9, so the next cycle sits at sub 10.
        cyc(1'b1, 1'b1, 5, 1'b0);
        repeat (50) cyc(1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b1);
        chk("resync_cycle_os", int'(s_os), 0);
        run_from("resync", 5, 80);

        cyc(1'b1, 1'b1, 4, 1'b0);
        repeat (30) cyc(1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b1, 2, 1'b1);
        chk("load_rs_old_div", int'(s_div), 4);
        run_from("load_rs", 2, 64);

        cyc(1'b1, 1'b1, 3, 1'b0);
        repeat (20) cyc(1'b1, 1'b0, 0, 1'b0);
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b0, 0, 1'b0);
            pulses += int'(s_os) + int'(s_baud) + int'(s_dbl);
        end
        chk("en_low_pulses", pulses, 0);
        run_from("reen", 3, 96);

        // Asynchronous reset while the D=1 tick is high, between clock edges.
        cyc(1'b1, 1'b1, 1, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 0, 1'b0);
        #2;
        chk("pre_arst_os", int'(oversample_edge_o), 1);
        rst_i = 1'b1;
        #1;
        chk("arst_os",   int'(oversample_edge_o),  0);
        chk("arst_baud", int'(baud_rate_edge_o),   0);
        chk("arst_dbl",  int'(double_rate_edge_o), 0);
        chk("arst_divo", int'(divisor_o),          0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cyc(1'b1, 1'b0, 0, 1'b0);
        chk("post_arst_os", int'(s_os), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
